// File: rtl/mat_vec_mac_con.sv
// Matrix-vector multiply-accumulate controller: streams a vector and NUM_PE rows
// from BRAM, runs NUM_PE parallel MAC lanes, then writes one 32-bit result per lane.
module mat_vec_mac_con #(
    parameter int VECTOR_SIZE = 16,
    parameter int NUM_PE      = 4,
    parameter int L_RAM_SIZE  = 4,
    parameter int RESULT_BASE = 256
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        start,
    input  logic        acc_en,
    output logic        busy,
    output logic        done,
    output logic [31:0] BRAM_ADDR,
    output logic [31:0] BRAM_WRDATA,
    output logic [3:0]  BRAM_WE,
    output logic        BRAM_CLK,
    input  logic [31:0] BRAM_RDDATA
);

    localparam int HALF     = VECTOR_SIZE / 2;
    localparam int W        = (NUM_PE + 1) * HALF;
    localparam int NUM_ELEM = (NUM_PE + 1) * VECTOR_SIZE;
    localparam int CNT_W    = $clog2(W + VECTOR_SIZE + NUM_PE) + 1;

    localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(W);
    localparam logic [CNT_W-1:0] CALC_LAST  = CNT_W'(VECTOR_SIZE - 1);
    localparam logic [CNT_W-1:0] WRITE_LAST = CNT_W'(NUM_PE - 1);

    typedef enum logic [2:0] {IDLE, LOAD, CALC, WRITE, DONE} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic                    acc_en_q;
    logic [31:0]             acc      [NUM_PE];
    logic signed [15:0]      elem_buf [NUM_ELEM];
    logic signed [15:0]      vec_k;
    logic signed [15:0]      row_k    [NUM_PE];
    logic [L_RAM_SIZE-1:0]   k_idx;

    assign BRAM_CLK = aclk;
    assign k_idx    = cnt[L_RAM_SIZE-1:0];

    // Element buffer: vector in [0, VECTOR_SIZE), row r in [(r+1)*VECTOR_SIZE, ...).
    // Word w lands one cycle after its address, i.e. while cnt == w+1.
    // NOTE: storage arrays get no reset; they are always reloaded before being read.
    always_ff @(posedge aclk) begin
        if (state == LOAD) begin
            for (int w = 0; w < W; w++) begin
                if (cnt == CNT_W'(w + 1)) begin
                    elem_buf[2*w]   <= BRAM_RDDATA[31:16];
                    elem_buf[2*w+1] <= BRAM_RDDATA[15:0];
                end
            end
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        vec_k = '0;
        for (int r = 0; r < NUM_PE; r++) row_k[r] = '0;
        for (int k = 0; k < VECTOR_SIZE; k++) begin
            if (k_idx == L_RAM_SIZE'(k)) begin
                vec_k = elem_buf[k];
                for (int r = 0; r < NUM_PE; r++) row_k[r] = elem_buf[(r+1)*VECTOR_SIZE + k];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= IDLE;
            cnt      <= '0;
            acc_en_q <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            for (int r = 0; r < NUM_PE; r++) acc[r] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= LOAD;
                        cnt      <= '0;
                        acc_en_q <= acc_en;
                        busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (cnt == LOAD_LAST) begin
                        state <= CALC;
                        cnt   <= '0;
                        if (!acc_en_q) begin
                            for (int r = 0; r < NUM_PE; r++) acc[r] <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CALC: begin
                    // Sign-extend before multiplying so the product is full precision.
                    for (int r = 0; r < NUM_PE; r++) begin
                        acc[r] <= acc[r] + 32'(row_k[r]) * 32'(vec_k);
                    end
                    if (cnt == CALC_LAST) begin
                        state <= WRITE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WRITE: begin
                    if (cnt == WRITE_LAST) begin
                        state <= DONE;
                        cnt   <= '0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // BRAM port is decoded from registered state, so reset clears it at once.
    always_comb begin
        BRAM_ADDR   = '0;
        BRAM_WRDATA = '0;
        BRAM_WE     = '0;
        case (state)
            LOAD: begin
                if (cnt < LOAD_LAST) BRAM_ADDR = 32'(cnt) << 2;
            end
            WRITE: begin
                BRAM_ADDR = (32'(RESULT_BASE) + 32'(cnt)) << 2;
                BRAM_WE   = 4'hF;
                for (int r = 0; r < NUM_PE; r++) begin
                    if (cnt == CNT_W'(r)) BRAM_WRDATA = acc[r];
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mat_vec_mac_con.sv
// Bench for mat_vec_mac_con: BRAM model, dot-product reference model and a
// cycle-by-cycle expected timeline for every run.
module tb_mat_vec_mac_con;

    localparam int VS       = 4;
    localparam int NPE      = 2;
    localparam int RB       = 16;
    localparam int W        = (NPE + 1) * VS / 2;
    localparam int DONE_CYC = W + 1 + VS + NPE;
    localparam int WR_FIRST = W + 1 + VS;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        start;
    logic        acc_en;
    logic        busy;
    logic        done;
    logic [31:0] bram_addr;
    logic [31:0] bram_wrdata;
    logic [3:0]  bram_we;
    logic        bram_clk;
    logic [31:0] bram_rddata;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] mem [0:63];
    int          vec_m [VS];
    int          row_m [NPE][VS];
    logic [31:0] model_acc [NPE];

    mat_vec_mac_con #(
        .VECTOR_SIZE(VS),
        .NUM_PE(NPE),
        .L_RAM_SIZE(2),
        .RESULT_BASE(RB)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .start(start),
        .acc_en(acc_en),
        .busy(busy),
        .done(done),
        .BRAM_ADDR(bram_addr),
        .BRAM_WRDATA(bram_wrdata),
        .BRAM_WE(bram_we),
        .BRAM_CLK(bram_clk),
        .BRAM_RDDATA(bram_rddata)
    );

    always #5 aclk = ~aclk;

    always @(posedge bram_clk) bram_rddata <= mem[bram_addr[7:2]];

    task automatic load_mem();
        for (int j = 0; j < VS / 2; j++)
            mem[j] = {16'(vec_m[2*j]), 16'(vec_m[2*j+1])};
        for (int r = 0; r < NPE; r++)
            for (int j = 0; j < VS / 2; j++)
                mem[(r+1)*VS/2 + j] = {16'(row_m[r][2*j]), 16'(row_m[r][2*j+1])};
    endtask

    function automatic logic [31:0] dot(input int r);
        longint s = 0;
        for (int k = 0; k < VS; k++) s += longint'(row_m[r][k]) * longint'(vec_m[k]);
        return s[31:0];
    endfunction

    task automatic set_basic();
        vec_m    = '{1, 2, 3, 4};
        row_m[0] = '{1, 1, 1, 1};
        row_m[1] = '{-1, 0, 2, 1};
    endtask

    // One run from the start edge (cycle 0) through cycle obs_len; each cycle the
    // outputs are compared to the timeline the model expects.
    task automatic run_job(input string tag, input bit ae, input int obs_len,
                           input int pulse_at, input int rst_at);
        logic [31:0] exp_res [NPE];
        bit          aborted;
        logic        eb, ed;
        logic [3:0]  ewe;
        logic [31:0] ea, ewd;
        for (int r = 0; r < NPE; r++) exp_res[r] = (ae ? model_acc[r] : 32'd0) + dot(r);
        load_mem();
        aborted = 1'b0;
        start   = 1'b1;
        acc_en  = ae;
        @(posedge aclk);
        #1;
        start  = 1'b0;
        acc_en = 1'($urandom);
        for (int n = 0; n <= obs_len; n++) begin
            bit chk_addr;
            @(negedge aclk);
            if (n == pulse_at) start = 1'b1;
            else if (n == pulse_at + 1) start = 1'b0;
            if (n == rst_at) begin
                aresetn = 1'b0;
                aborted = 1'b1;
            end else if (n == rst_at + 1) begin
                aresetn = 1'b1;
            end
            #1;
            eb = 1'b0; ed = 1'b0; ewe = 4'h0; ea = 32'd0; ewd = 32'd0;
            if (!aborted) begin
                eb = (n <= DONE_CYC);
                ed = (n == DONE_CYC);
                if (n < W) ea = 32'(n * 4);
                if (n >= WR_FIRST && n < WR_FIRST + NPE) begin
                    ewe = 4'hF;
                    ea  = 32'((RB + n - WR_FIRST) * 4);
                    ewd = exp_res[n - WR_FIRST];
                end
            end
            chk_addr = !(n == W && !aborted);
            vectors++;
            if ({busy, done, bram_we, bram_wrdata} !== {eb, ed, ewe, ewd} ||
                (chk_addr && bram_addr !== ea)) begin
                miscompares++;
                $display("FAIL %s cyc%0d: got busy=%b done=%b we=%h addr=%h wd=%h, want busy=%b done=%b we=%h addr=%h wd=%h",
                         tag, n, busy, done, bram_we, bram_addr, bram_wrdata, eb, ed, ewe, ea, ewd);
            end
        end
        start = 1'b0;
        if (aborted) model_acc = '{default: 32'd0};
        else model_acc = exp_res;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        start   = 1'b0;
        acc_en  = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        model_acc = '{default: 32'd0};
        repeat (2) @(negedge aclk);
        #1;
        vectors++;
        if ({busy, done, bram_we, bram_addr, bram_wrdata} !== 70'd0) begin
            miscompares++;
            $display("FAIL reset: got busy=%b done=%b we=%h addr=%h wd=%h, want all zero",
                     busy, done, bram_we, bram_addr, bram_wrdata);
        end
        aresetn = 1'b1;
        repeat (3) begin
            @(negedge aclk);
            vectors++;
            if ({busy, done, bram_we} !== 6'd0) begin
                miscompares++;
                $display("FAIL idle: got busy=%b done=%b we=%h, want 0 0 0", busy, done, bram_we);
            end
        end
    endtask

    task automatic test_basic();
        set_basic();
        run_job("basic", 1'b0, DONE_CYC + 1, -1, -1);
    endtask

    task automatic test_accumulate();
        set_basic();
        run_job("accumulate", 1'b1, DONE_CYC + 1, -1, -1);
    endtask

    task automatic test_wrap();
        vec_m    = '{default: -32768};
        row_m[0] = '{default: -32768};
        row_m[1] = '{default: -32768};
        run_job("wrap", 1'b0, DONE_CYC + 1, -1, -1);
    endtask

    task automatic test_start_while_busy();
        set_basic();
        run_job("start_busy", 1'b0, DONE_CYC + 8, W + 2, -1);
    endtask

    task automatic test_reset_mid_run();
        set_basic();
        run_job("abort", 1'b1, DONE_CYC + 8, -1, W + 3);
        run_job("after_abort", 1'b1, DONE_CYC + 1, -1, -1);
    endtask

    task automatic test_back_to_back();
        set_basic();
        run_job("b2b_first", 1'b0, DONE_CYC + 1, -1, -1);
        run_job("b2b_second", 1'b1, DONE_CYC + 1, -1, -1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < VS; k++) begin
                vec_m[k] = int'($urandom_range(65535, 0)) - 32768;
                for (int r = 0; r < NPE; r++) row_m[r][k] = int'($urandom_range(65535, 0)) - 32768;
            end
            if (i == 0) vec_m[0] = 32767;
            run_job("random", 1'($urandom), DONE_CYC + 1, -1, -1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_accumulate();
        test_wrap();
        test_start_while_busy();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mat_vec_mac_con.md
MAT_VEC_MAC_CON -- requirements
Module: mat_vec_mac_con

Interface
REQ-001 SHALL have parameter VECTOR_SIZE, default 16, meaning elements per vector/row (power of 2, >= 2).
REQ-002 SHALL have parameter NUM_PE, default 4, meaning parallel MAC lanes and matrix rows.
REQ-003 SHALL have parameter L_RAM_SIZE, default 4, meaning log2(VECTOR_SIZE).
REQ-004 SHALL have parameter RESULT_BASE, default 256, meaning the word address of the first result.
REQ-005 SHALL have port aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port aresetn, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port start, input, 1 bit: run request, sampled only in IDLE.
REQ-008 SHALL have port acc_en, input, 1 bit: accumulate mode, sampled together with start.
REQ-009 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port BRAM_ADDR, output, 32 bits: byte address, equal to word address << 2.
REQ-012 SHALL have port BRAM_WRDATA, output, 32 bits: result write data.
REQ-013 SHALL have port BRAM_WE, output, 4 bits: byte write enables.
REQ-014 SHALL have port BRAM_CLK, output, 1 bit: equal to aclk.
REQ-015 SHALL have port BRAM_RDDATA, input, 32 bits: read data, valid one cycle after the address.

Function
REQ-016 SHALL use states IDLE, LOAD, CALC, WRITE, DONE, sequenced IDLE->LOAD->CALC->WRITE->DONE->IDLE with no other transitions.
REQ-017 SHALL move from IDLE to LOAD at the edge where start=1; start in any other state is ignored and not queued.
REQ-018 SHALL latch acc_en at that same edge.
REQ-019 SHALL use this memory layout:
  - vector: words 0..VECTOR_SIZE/2-1
  - row r: words (r+1)*VECTOR_SIZE/2 onward
  - packing: element 2j in bits [31:16], element 2j+1 in bits [15:0]
  - elements are signed 16-bit.
REQ-020 SHALL run LOAD for W+1 cycles, where W=(NUM_PE+1)*VECTOR_SIZE/2:
  - addresses 0..W-1 are issued in ascending order, one per cycle
  - each data word is captured into the local vector or row buffers one cycle after its address.
REQ-021 SHALL run CALC for exactly VECTOR_SIZE cycles; in cycle k each lane r does acc[r] += row[r][k]*vec[k].
REQ-022 SHALL form each product full-precision at 32 bits; accumulation wraps modulo 2^32 with no saturation.
REQ-023 SHALL clear acc[r] to 0 on entry to CALC when the latched acc_en=0, and keep the previous run's value when acc_en=1.
REQ-024 SHALL run WRITE for NUM_PE cycles; in cycle r:
  - BRAM_ADDR=(RESULT_BASE+r)<<2
  - BRAM_WRDATA=acc[r]
  - BRAM_WE=4'hF.
REQ-025 SHALL hold BRAM_WE=0 in all other cycles, with BRAM_ADDR=0 and BRAM_WRDATA=0 outside LOAD and WRITE.
REQ-026 SHALL spend one cycle in DONE with done=1, then return to IDLE.
REQ-027 SHALL make done high exactly W+1+VECTOR_SIZE+NUM_PE cycles after the start-sampling edge.
REQ-028 SHALL assert busy in the cycle after start is sampled, through DONE inclusive.
REQ-029 SHALL accept start=1 in the cycle immediately after DONE as a new run.

Reset
REQ-030 SHALL, while aresetn=0, immediately force:
  - state=IDLE
  - busy=0, done=0
  - BRAM_WE=0, BRAM_ADDR=0, BRAM_WRDATA=0
  - all accumulators and the latched acc_en to 0.
REQ-031 SHALL, on reset mid-run, abandon the run: no further BRAM writes and no done pulse.
REQ-032 SHALL leave buffer contents undefined after reset; they are never read before being reloaded.

Verification
Scenario parameters: VECTOR_SIZE=4, NUM_PE=2, RESULT_BASE=16. So W=6 and done occurs 13 cycles after start.
REQ-033 SHALL verify a basic run:
  - stimulus: vec=[1,2,3,4], row0=[1,1,1,1], row1=[-1,0,2,1], acc_en=0
  - required: write 10 to byte address 64 and 9 to byte address 68, and done at cycle +13.
REQ-034 SHALL verify accumulate mode: rerun the same data with acc_en=1 -> write 20 and 18.
REQ-035 SHALL verify wrap-around:
  - stimulus: all elements -32768, acc_en=0
  - required: both results equal 0, since 4*2^30 wraps modulo 2^32.
REQ-036 SHALL verify start while busy: pulse start during CALC -> no second run and exactly one done.
REQ-037 SHALL verify reset mid-run:
  - stimulus: aresetn low during CALC cycle 2, then a fresh start with acc_en=1
  - required: no writes from the aborted run, and results 10 and 9 with accumulators starting from 0.
REQ-038 SHALL verify BRAM_WE=4'hF only in the 2 WRITE cycles of every run.
